// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator driving DDS tuning words and ADSR key states
// Optional feature macro VOICE_STEAL_EN: steal the oldest voice instead of dropping when all are busy.
module voice_allocator #(
   parameter int NUM_VOICES   = 4,
   parameter int MIDI_CHANNEL = 0,
   parameter bit OMNI         = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     midi_byte_ready,
   input  logic [7:0]               midi_byte0,
   input  logic [7:0]               midi_byte1,
   input  logic [7:0]               midi_byte2,
   output logic [7:0]               lookup_note,
   input  logic [31:0]              lookup_code,
   output logic [32*NUM_VOICES-1:0] dds_frequency,
   output logic [NUM_VOICES-1:0]    key_state,
   output logic [NUM_VOICES-1:0]    voice_trigger,
   output logic                     busy,
   output logic                     steal
);
   localparam int AW = $clog2(NUM_VOICES);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_DECODE     = 3'd1;
   localparam logic [2:0] S_SEARCH_ON  = 3'd2;
   localparam logic [2:0] S_COMMIT     = 3'd3;
   localparam logic [2:0] S_SEARCH_OFF = 3'd4;

   logic [2:0]    state;
   logic [7:0]    status;
   logic [7:0]    velocity;
   logic [7:0]    note [NUM_VOICES];
   logic [AW-1:0] age  [NUM_VOICES];
   logic [AW-1:0] target;
   logic [AW-1:0] target_age;
   logic          target_valid;
   logic          target_steal;

   logic          hit_found, free_found;
   logic [AW-1:0] hit_idx, free_idx, hit_age, free_age;
`ifdef VOICE_STEAL_EN
   logic [AW-1:0] old_idx, old_age;
`endif

   assign busy = (state != S_IDLE);

   // lookup_note doubles as the captured note number for the whole event
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      hit_age    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      free_age   = '0;
`ifdef VOICE_STEAL_EN
      old_idx    = '0;
      old_age    = age[0];
`endif
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (!hit_found && key_state[v] && note[v] == lookup_note) begin
            hit_found = 1'b1;
            hit_idx   = AW'(v);
            hit_age   = age[v];
         end
         if (!free_found && !key_state[v]) begin
            free_found = 1'b1;
            free_idx   = AW'(v);
            free_age   = age[v];
         end
`ifdef VOICE_STEAL_EN
         if (age[v] > old_age) begin
            old_age = age[v];
            old_idx = AW'(v);
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         status        <= '0;
         velocity      <= '0;
         lookup_note   <= '0;
         dds_frequency <= '0;
         key_state     <= '0;
         voice_trigger <= '0;
         steal         <= 1'b0;
         target        <= '0;
         target_age    <= '0;
         target_valid  <= 1'b0;
         target_steal  <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            note[v] <= '0;
            age[v]  <= '0;
         end
      end else begin
         voice_trigger <= '0;
         steal         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (midi_byte_ready) begin
                  status      <= midi_byte0;
                  lookup_note <= midi_byte1;
                  velocity    <= midi_byte2;
                  state       <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!OMNI && status[3:0] != 4'(MIDI_CHANNEL))
                  state <= S_IDLE;
               else if (status[7:4] == 4'h9 && velocity != 8'd0)
                  state <= S_SEARCH_ON;
               else if (status[7:4] == 4'h8 || status[7:4] == 4'h9)
                  state <= S_SEARCH_OFF;
               else
                  state <= S_IDLE;
            end
            S_SEARCH_ON: begin
               if (hit_found) begin
                  target       <= hit_idx;
                  target_age   <= hit_age;
                  target_valid <= 1'b1;
                  target_steal <= 1'b0;
               end else if (free_found) begin
                  target       <= free_idx;
                  target_age   <= free_age;
                  target_valid <= 1'b1;
                  target_steal <= 1'b0;
               end else begin
`ifdef VOICE_STEAL_EN
                  target       <= old_idx;
                  target_age   <= old_age;
                  target_valid <= 1'b1;
`else
                  target_valid <= 1'b0;
`endif
                  target_steal <= 1'b1;
               end
               state <= S_COMMIT;
            end
            S_COMMIT: begin
               if (target_valid) begin
                  for (int v = 0; v < NUM_VOICES; v++) begin
                     if (AW'(v) == target) begin
                        dds_frequency[32*v +: 32] <= lookup_code;
                        note[v]          <= lookup_note;
                        key_state[v]     <= 1'b1;
                        voice_trigger[v] <= 1'b1;
                        age[v]           <= '0;
                     end else if (age[v] < target_age) begin
                        age[v] <= age[v] + AW'(1);
                     end
                  end
               end
               // without stealing this same pulse reports a dropped note-on
               steal <= target_steal;
               state <= S_IDLE;
            end
            S_SEARCH_OFF: begin
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (key_state[v] && note[v] == lookup_note)
                     key_state[v] <= 1'b0;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator (omni and channel-2 instances)
module tb_voice_allocator;
   localparam int NV = 4;

   typedef struct {
      int            lat;
      logic [NV-1:0] key;
      logic [32*NV-1:0] freq;
      logic [NV-1:0] trig;
      logic          stl;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic midi_byte_ready = 1'b0;
   logic [7:0] midi_byte0 = '0;
   logic [7:0] midi_byte1 = '0;
   logic [7:0] midi_byte2 = '0;

   logic [7:0]       lookup_note_a, lookup_note_c;
   logic [31:0]      lookup_code_a, lookup_code_c;
   logic [32*NV-1:0] dds_a, dds_c;
   logic [NV-1:0]    key_a, key_c, trig_a, trig_c;
   logic             busy_a, busy_c, steal_a, steal_c;

   bit               sel = 1'b0;
   logic [7:0]       lookup_note_o;
   logic [32*NV-1:0] dds_o;
   logic [NV-1:0]    key_o, trig_o;
   logic             busy_o, steal_o;

   int   n_vectors = 0;
   int   n_miscompares = 0;
   exp_t sb[$];
   string sb_tag[$];

   logic [7:0]       m_note [NV];
   logic [NV-1:0]    m_key;
   logic [32*NV-1:0] m_freq;
   int               m_age [NV];
   bit               m_omni = 1'b1;
   logic [3:0]       m_chan = 4'd0;

   function automatic logic [31:0] code_of(input logic [7:0] n);
      if (n == 8'd60) return 32'h01234567;
      return {n, ~n, n ^ 8'h5A, 8'hC3};
   endfunction

   assign lookup_code_a = code_of(lookup_note_a);
   assign lookup_code_c = code_of(lookup_note_c);

   assign lookup_note_o = sel ? lookup_note_c : lookup_note_a;
   assign dds_o   = sel ? dds_c   : dds_a;
   assign key_o   = sel ? key_c   : key_a;
   assign trig_o  = sel ? trig_c  : trig_a;
   assign busy_o  = sel ? busy_c  : busy_a;
   assign steal_o = sel ? steal_c : steal_a;

   voice_allocator #(.NUM_VOICES(NV), .MIDI_CHANNEL(0), .OMNI(1'b1)) dut (
      .clk(clk), .reset(reset), .midi_byte_ready(midi_byte_ready),
      .midi_byte0(midi_byte0), .midi_byte1(midi_byte1), .midi_byte2(midi_byte2),
      .lookup_note(lookup_note_a), .lookup_code(lookup_code_a),
      .dds_frequency(dds_a), .key_state(key_a), .voice_trigger(trig_a),
      .busy(busy_a), .steal(steal_a)
   );

   voice_allocator #(.NUM_VOICES(NV), .MIDI_CHANNEL(2), .OMNI(1'b0)) dut_ch (
      .clk(clk), .reset(reset), .midi_byte_ready(midi_byte_ready),
      .midi_byte0(midi_byte0), .midi_byte1(midi_byte1), .midi_byte2(midi_byte2),
      .lookup_note(lookup_note_c), .lookup_code(lookup_code_c),
      .dds_frequency(dds_c), .key_state(key_c), .voice_trigger(trig_c),
      .busy(busy_c), .steal(steal_c)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_key  = '0;
      m_freq = '0;
      for (int v = 0; v < NV; v++) begin
         m_note[v] = '0;
         m_age[v]  = 0;
      end
   endtask

   task automatic model_push(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
      exp_t e;
      int tgt, old;
      e.lat  = 1;
      e.trig = '0;
      e.stl  = 1'b0;
      if (m_omni || b0[3:0] == m_chan) begin
         if (b0[7:4] == 4'h9 && b2 != 8'd0) begin
            e.lat = 3;
            tgt = -1;
            for (int v = 0; v < NV; v++)
               if (tgt < 0 && m_key[v] && m_note[v] == b1) tgt = v;
            for (int v = 0; v < NV; v++)
               if (tgt < 0 && !m_key[v]) tgt = v;
            if (tgt < 0) begin
               e.stl = 1'b1;
`ifdef VOICE_STEAL_EN
               tgt = 0;
               for (int v = 1; v < NV; v++)
                  if (m_age[v] > m_age[tgt]) tgt = v;
`endif
            end
            if (tgt >= 0) begin
               old = m_age[tgt];
               for (int v = 0; v < NV; v++)
                  if (v != tgt && m_age[v] < old) m_age[v]++;
               m_age[tgt]  = 0;
               m_note[tgt] = b1;
               m_key[tgt]  = 1'b1;
               m_freq[32*tgt +: 32] = code_of(b1);
               e.trig[tgt] = 1'b1;
            end
         end else if (b0[7:4] == 4'h8 || b0[7:4] == 4'h9) begin
            e.lat = 2;
            for (int v = 0; v < NV; v++)
               if (m_key[v] && m_note[v] == b1) m_key[v] = 1'b0;
         end
      end
      e.key  = m_key;
      e.freq = m_freq;
      sb.push_back(e);
      sb_tag.push_back(tag);
   endtask

   task automatic collect();
      exp_t e;
      string tag;
      int lat = 0;
      while (busy_o === 1'b1 && lat < 16) begin
         lat++;
         @(negedge clk);
         midi_byte_ready = 1'b0;
      end
      e   = sb.pop_front();
      tag = sb_tag.pop_front();
      check({tag, "_busy_cycles"}, lat, e.lat);
      check({tag, "_key_state"}, key_o, e.key);
      check({tag, "_dds_frequency"}, dds_o, e.freq);
      check({tag, "_voice_trigger"}, trig_o, e.trig);
      check({tag, "_steal"}, steal_o, e.stl);
   endtask

   task automatic send(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input bit inject);
      midi_byte0 = b0;
      midi_byte1 = b1;
      midi_byte2 = b2;
      midi_byte_ready = 1'b1;
      model_push(tag, b0, b1, b2);
      @(negedge clk);
      midi_byte_ready = 1'b0;
      check({tag, "_lookup_note"}, lookup_note_o, b1);
      if (inject) begin
         midi_byte0 = 8'h92;
         midi_byte1 = 8'd67;
         midi_byte2 = 8'd100;
         midi_byte_ready = 1'b1;
      end
      collect();
   endtask

   task automatic do_reset();
      midi_byte_ready = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      model_clear();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_key_a"}, key_a, '0);
      check({tag, "_dds_a"}, dds_a, '0);
      check({tag, "_trig_a"}, trig_a, '0);
      check({tag, "_busy_a"}, busy_a, '0);
      check({tag, "_steal_a"}, steal_a, '0);
      check({tag, "_lookup_a"}, lookup_note_a, '0);
      check({tag, "_key_c"}, key_c, '0);
      check({tag, "_dds_c"}, dds_c, '0);
      check({tag, "_busy_c"}, busy_c, '0);
      check({tag, "_lookup_c"}, lookup_note_c, '0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check_all_zero("reset");

      send("on60", 8'h90, 8'd60, 8'd100, 1'b0);
      check("on60_word0", dds_o[31:0], 32'h01234567);
      send("retrig60", 8'h90, 8'd60, 8'd100, 1'b0);
      send("on64", 8'h90, 8'd64, 8'd100, 1'b0);
      send("on67", 8'h90, 8'd67, 8'd100, 1'b0);
      send("on72", 8'h90, 8'd72, 8'd100, 1'b0);
      check("all_voices_on", key_o, 4'b1111);
      send("on76_full", 8'h90, 8'd76, 8'd100, 1'b0);

      do_reset();
      send("off_on60", 8'h90, 8'd60, 8'd100, 1'b0);
      send("off_on64", 8'h90, 8'd64, 8'd100, 1'b0);
      send("off64", 8'h80, 8'd64, 8'd0, 1'b0);
      send("vel0_off60", 8'h90, 8'd60, 8'd0, 1'b0);
      send("ctrl_change", 8'hB0, 8'd7, 8'd100, 1'b0);
      send("off_nomatch", 8'h80, 8'd99, 8'd0, 1'b0);

      sel    = 1'b1;
      m_omni = 1'b0;
      m_chan = 4'd2;
      do_reset();
      send("ch3_on", 8'h93, 8'd60, 8'd100, 1'b0);
      send("ch2_on", 8'h92, 8'd60, 8'd100, 1'b0);
      send("ch2_busy_strobe", 8'h92, 8'd64, 8'd100, 1'b1);

      sel    = 1'b0;
      m_omni = 1'b1;
      m_chan = 4'd0;
      do_reset();
      send("pre_abort", 8'h90, 8'd60, 8'd100, 1'b0);
      midi_byte0 = 8'h90;
      midi_byte1 = 8'd72;
      midi_byte2 = 8'd100;
      midi_byte_ready = 1'b1;
      @(negedge clk);
      midi_byte_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_in_commit", busy_a, 1'b1);
      reset = 1'b1;
      #1;
      check_all_zero("abort_async");
      @(negedge clk);
      check_all_zero("abort_held");
      reset = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
